// File: rtl/vga_scanout.sv
// VGA scan-out: 640x480@60 timing, double-buffered frame buffer fetch, pin pipeline
// aligned to RAM read latency, and vblank buffer-swap handshake. Optional colour
// bars are compiled in with `define TEST_PATTERN_EN (adds the test_mode input).
module vga_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int RD_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
`ifdef TEST_PATTERN_EN
  input  logic        test_mode,
`endif
  output logic        rd_en,
  output logic        rd_bank,
  output logic [18:0] rd_addr,
  input  logic [2:0]  rd_data,
  input  logic        swap_req,
  output logic        swap_ack,
  output logic        frame_end,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic [2:0]  rgb
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  // Counter -> pin distance is STAGES+1 registers: 1 address stage + RD_LATENCY + rgb.
  localparam int STAGES = RD_LATENCY + 1;

  localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_PRE  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          active, origin, hs_n, vs_n, pre_end, tp_now;

  logic [STAGES:0] de_pipe, hs_pipe, vs_pipe;

  // ---------------------------------------------------------------- counters
  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  assign active  = (h < H_ACT) && (v < V_ACT);
  assign origin  = (h == '0) && (v == '0);
  assign hs_n    = !((h >= HS_BEG) && (h <= HS_END));
  assign vs_n    = !((v >= VS_BEG) && (v <= VS_END));
  // Next counter state is (0, V_ACTIVE): lets frame_end/swap_ack/rd_bank be registered
  // yet line up exactly with that counter cycle.
  assign pre_end = (h == H_LAST) && (v == V_PRE);

`ifdef TEST_PATTERN_EN
  localparam int BAR_W = H_ACTIVE / 8;

  logic                    tp_q;
  logic [2:0]              bar;
  logic [STAGES-1:0]       tp_pipe;
  logic [STAGES-1:0][2:0]  bar_pipe;

  // test_mode only takes effect at the frame origin so a frame is never split.
  assign tp_now = origin ? test_mode : tp_q;
  assign bar    = 3'(32'(h) / BAR_W);

  always_ff @(posedge clk) begin
    if (reset) begin
      tp_q     <= 1'b0;
      tp_pipe  <= '0;
      bar_pipe <= '0;
    end else begin
      tp_q     <= tp_now;
      tp_pipe  <= {tp_pipe[STAGES-2:0], tp_now};
      bar_pipe <= {bar_pipe[STAGES-2:0], bar};
    end
  end
`else
  assign tp_now = 1'b0;
`endif

  // ---------------------------------------------------------------- address stage
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= active && !tp_now;
      if (origin)
        rd_addr <= '0;
      else if (active && !tp_now)
        rd_addr <= rd_addr + 19'd1;
    end
  end

  // ---------------------------------------------------------------- swap handshake
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_bank   <= 1'b0;
      swap_ack  <= 1'b0;
      frame_end <= 1'b0;
    end else begin
      frame_end <= pre_end;
      swap_ack  <= pre_end && swap_req;
      if (pre_end && swap_req)
        rd_bank <= ~rd_bank;
    end
  end

  // ---------------------------------------------------------------- pin pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      de_pipe <= '0;
      hs_pipe <= '1;
      vs_pipe <= '1;
    end else begin
      de_pipe <= {de_pipe[STAGES-1:0], active};
      hs_pipe <= {hs_pipe[STAGES-1:0], hs_n};
      vs_pipe <= {vs_pipe[STAGES-1:0], vs_n};
    end
  end

  // rd_data for a pixel lands while its de sits one stage short of the pins.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb <= '0;
    end else if (de_pipe[STAGES-1]) begin
`ifdef TEST_PATTERN_EN
      rgb <= tp_pipe[STAGES-1] ? bar_pipe[STAGES-1] : rd_data;
`else
      rgb <= rd_data;
`endif
    end else begin
      rgb <= '0;
    end
  end

  assign de    = de_pipe[STAGES];
  assign hsync = hs_pipe[STAGES];
  assign vsync = vs_pipe[STAGES];

endmodule
